// File: rtl/multicycle_maindec_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_maindec_if
//  Purpose  : Control bundle between the multicycle main decoder and the
//             datapath: opcode in, mux selects / write enables / debug out.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_maindec_if;
    logic [5:0] op;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       illegal;
    logic [3:0] state;

    // Decoder side: consumes the opcode, drives every control line
    modport master (
        input  op,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcwrite, branch,
               illegal, state
    );

    // Datapath side: supplies the opcode from the IR, obeys the controls
    modport slave (
        output op,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcwrite, branch,
               illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_maindec.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_maindec
//  Purpose  : Main control FSM of the multicycle MIPS core. Walks each
//             instruction through fetch/decode/execute/memory/writeback and
//             drives the datapath selects and write enables per state.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_maindec #(
    parameter bit ADDI_EN = 1'b1,
    parameter bit J_EN    = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    multicycle_maindec_if.master  bus
);

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    state_t w_dispatch;
    logic   w_legal;

    // Control word for a given state; anything not named stays 0
    function automatic ctrl_t f_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            S_DECODE: begin c.alusrcb = 2'b11; end
            S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:  begin c.iord = 1'b1; end
            S_MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BRANCH: begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB: begin c.regwrite = 1'b1; end
            S_JUMP:   begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Opcode dispatch out of DECODE; disabled opcodes fall through as illegal
    always_comb begin
        w_dispatch = S_FETCH;
        w_legal    = 1'b0;
        case (bus.op)
            c_OP_LW, c_OP_SW: begin w_dispatch = S_MEMADR; w_legal = 1'b1; end
            c_OP_RTYPE:       begin w_dispatch = S_EXEC;   w_legal = 1'b1; end
            c_OP_BEQ:         begin w_dispatch = S_BRANCH; w_legal = 1'b1; end
            c_OP_ADDI: if (ADDI_EN) begin w_dispatch = S_ADDIEX; w_legal = 1'b1; end
            c_OP_J:    if (J_EN)    begin w_dispatch = S_JUMP;   w_legal = 1'b1; end
            default:          begin w_dispatch = S_FETCH;  w_legal = 1'b0; end
        endcase
    end

    // Next-state selection; unused codes recover to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = w_dispatch;
            // op is looked at again here; an IR that changed to neither
            // lw nor sw abandons the access rather than guessing
            S_MEMADR: begin
                if (bus.op == c_OP_LW)      w_next = S_MEMRD;
                else if (bus.op == c_OP_SW) w_next = S_MEMWR;
                else                        w_next = S_FETCH;
            end
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // State register with control word registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= f_ctrl(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next);
        end
    end

    // Write enables are masked by reset so no partial write can land
    assign bus.irwrite  = r_ctrl.irwrite  & ~reset;
    assign bus.pcwrite  = r_ctrl.pcwrite  & ~reset;
    assign bus.memwrite = r_ctrl.memwrite & ~reset;
    assign bus.regwrite = r_ctrl.regwrite & ~reset;
    assign bus.branch   = r_ctrl.branch   & ~reset;

    assign bus.iord     = r_ctrl.iord;
    assign bus.regdst   = r_ctrl.regdst;
    assign bus.memtoreg = r_ctrl.memtoreg;
    assign bus.alusrca  = r_ctrl.alusrca;
    assign bus.alusrcb  = r_ctrl.alusrcb;
    assign bus.aluop    = r_ctrl.aluop;
    assign bus.pcsrc    = r_ctrl.pcsrc;

    // The IR is only valid once DECODE is reached, so illegal looks at op live
    assign bus.illegal  = (r_state == S_DECODE) && !w_legal;
    assign bus.state    = r_state;

endmodule
`default_nettype wire
